delta_encoding_mul_arbiter: RTL

//   Shares one unsigned 5x11 delta-encoding multiplier among NUM_REQ channel requesters.
//   - Round-robin arbitration with per-requester valid/ready.
//   - Two-stage pipeline: operand register, then combinational multiply into a result register.
//   - Tagged results are returned on a single valid/ready output port.
//   - Sits between the per-channel delta encoders and the shared multiplier datapath.

---
 rtl/delta_encoding_mul_arbiter_if.sv | 70 +++++++
 rtl/delta_encoding_mul_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/delta_encoding_mul_arbiter_if.sv
// -----------------------------------------------------------------------------
// delta_encoding_mul_arbiter_if
//
// Purpose:
//   Bundles the request, result and control/status signals of the shared
//   delta-encoding multiplier arbiter into one interface. Clock and reset stay
//   outside as plain ports on the arbiter.
//
// Signals:
//   cfg_en     1            grant enable (0 = no new grants, pipeline drains)
//   req_valid  NUM_REQ      per-requester request valid
//   req_ready  NUM_REQ      per-requester accept, one-hot or zero
//   req_a      NUM_REQ*A_W  packed operand A, requester i at [i*A_W +: A_W]
//   req_b      NUM_REQ*B_W  packed operand B, requester i at [i*B_W +: B_W]
//   res_valid  1            result valid
//   res_ready  1            downstream accepts the result
//   res_data   P_W          truncated product
//   res_id     ID_W         tag of the requester that issued the product
//   idle       1            both pipeline stages empty
//
// Modports:
//   master  requester/consumer side (drives requests, consumes results)
//   slave   arbiter side
// -----------------------------------------------------------------------------
interface delta_encoding_mul_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int A_W     = 5,
   parameter int B_W     = 11,
   parameter int P_W     = 15,
   parameter int ID_W    = 2
) ();

   logic                   cfg_en;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*A_W-1:0] req_a;
   logic [NUM_REQ*B_W-1:0] req_b;
   logic                   res_valid;
   logic                   res_ready;
   logic [P_W-1:0]         res_data;
   logic [ID_W-1:0]        res_id;
   logic                   idle;

   modport master (
      output cfg_en,
      output req_valid,
      input  req_ready,
      output req_a,
      output req_b,
      input  res_valid,
      output res_ready,
      input  res_data,
      input  res_id,
      input  idle
   );

   modport slave (
      input  cfg_en,
      input  req_valid,
      output req_ready,
      input  req_a,
      input  req_b,
      output res_valid,
      input  res_ready,
      output res_data,
      output res_id,
      output idle
   );

endinterface

// File: rtl/delta_encoding_mul_arbiter.sv
// -----------------------------------------------------------------------------
// delta_encoding_mul_arbiter
//
// Purpose:
//   Shares one unsigned A_W x B_W multiplier among NUM_REQ delta-encoder
//   channels. A round-robin arbiter picks one requester per cycle, its operands
//   are captured into stage S1, the product is formed combinationally and
//   registered into stage S2, and tagged results leave on a single valid/ready
//   port. Both stages can advance in the same cycle, giving one result per
//   cycle when downstream keeps up.
//
// Ports:
//   ap_clk       in   clock, rising edge
//   ap_rst_n     in   synchronous reset, active-low
//   bus          slave modport of delta_encoding_mul_arbiter_if (requests,
//                results, cfg_en, idle)
//   stat_grants  out  32-bit saturating handshake count  (stats build only)
//   stat_stalls  out  32-bit saturating stall-cycle count (stats build only)
//
// Configuration:
//   DELTA_MUL_ARB_STATS_EN  when defined, adds the stat_grants/stat_stalls
//                           ports and their counters. When undefined those
//                           ports do not exist; everything else is identical.
// -----------------------------------------------------------------------------
module delta_encoding_mul_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int A_W     = 5,
   parameter int B_W     = 11,
   parameter int P_W     = 15,
   parameter int ID_W    = 2
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst_n,
   delta_encoding_mul_arbiter_if.slave  bus
`ifdef DELTA_MUL_ARB_STATS_EN
   ,
   output logic [31:0]                  stat_grants,
   output logic [31:0]                  stat_stalls
`endif
);

   localparam int FULL_W = A_W + B_W;

   // Pipeline state
   logic              r_s1Valid;
   logic [A_W-1:0]    r_s1A;
   logic [B_W-1:0]    r_s1B;
   logic [ID_W-1:0]   r_s1Id;
   logic              r_s2Valid;
   logic [P_W-1:0]    r_s2Data;
   logic [ID_W-1:0]   r_s2Id;
   logic [ID_W-1:0]   r_rrPtr;

   // Combinational control
   logic              w_s2Free;
   logic              w_s1Free;
   logic              w_accept;
   logic              w_anyReq;
   logic [ID_W-1:0]   w_grantIdx;
   logic [NUM_REQ-1:0] w_grant;
   logic              w_handshake;
   logic [ID_W-1:0]   w_nextPtr;
   logic [A_W-1:0]    w_selA;
   logic [B_W-1:0]    w_selB;
   logic [FULL_W-1:0] w_fullProd;
   logic [P_W-1:0]    w_prod;

   // A stage is free when it is empty or when its content moves on this cycle,
   // so S1 can refill in the same cycle S2 pops.
   assign w_s2Free = !r_s2Valid || bus.res_ready;
   assign w_s1Free = !r_s1Valid || w_s2Free;
   assign w_accept = bus.cfg_en && w_s1Free;

   // Round-robin search: scan from r_rrPtr upward with wrap, take the first
   // requester with valid set. The scan index is wrapped by subtraction so a
   // non-power-of-two NUM_REQ still works.
   always_comb begin
      int cand;
      w_anyReq   = 1'b0;
      w_grantIdx = '0;
      cand       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(r_rrPtr) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!w_anyReq && bus.req_valid[ID_W'(cand)]) begin
            w_anyReq   = 1'b1;
            w_grantIdx = ID_W'(cand);
         end
      end
   end

   assign w_grant       = NUM_REQ'(w_anyReq) << w_grantIdx;
   assign bus.req_ready = w_grant & {NUM_REQ{w_accept}};
   assign w_handshake   = w_anyReq && w_accept;

   // Pointer moves to the slot after the winner, wrapping at NUM_REQ-1.
   assign w_nextPtr = (w_grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : w_grantIdx + 1'b1;

   // Operand slices of the granted requester
   assign w_selA = bus.req_a[int'(w_grantIdx)*A_W +: A_W];
   assign w_selB = bus.req_b[int'(w_grantIdx)*B_W +: B_W];

   // Full-width unsigned product; only the low P_W bits are kept, higher bits
   // are dropped on purpose.
   assign w_fullProd = FULL_W'(r_s1A) * FULL_W'(r_s1B);
   assign w_prod     = w_fullProd[P_W-1:0];

   // Valid bits, round-robin pointer and the S2 result register. Reset clears
   // everything in flight and has priority over any handshake in the same
   // cycle.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         r_s1Valid <= 1'b0;
         r_s2Valid <= 1'b0;
         r_rrPtr   <= '0;
         r_s2Data  <= '0;
         r_s2Id    <= '0;
      end else begin
         r_s1Valid <= w_handshake || (r_s1Valid && !w_s2Free);
         r_s2Valid <= (r_s1Valid && w_s2Free) || (r_s2Valid && !bus.res_ready);
         if (w_handshake) begin
            r_rrPtr <= w_nextPtr;
         end
         if (r_s1Valid && w_s2Free) begin
            r_s2Data <= w_prod;
            r_s2Id   <= r_s1Id;
         end
      end
   end

   // S1 operand/tag capture. These are qualified by r_s1Valid downstream, so
   // they need no reset.
   always_ff @(posedge ap_clk) begin
      if (w_handshake) begin
         r_s1A  <= w_selA;
         r_s1B  <= w_selB;
         r_s1Id <= w_grantIdx;
      end
   end

   assign bus.res_valid = r_s2Valid;
   assign bus.res_data  = r_s2Data;
   assign bus.res_id    = r_s2Id;
   assign bus.idle      = !r_s1Valid && !r_s2Valid;

`ifdef DELTA_MUL_ARB_STATS_EN
   logic [31:0] r_statGrants;
   logic [31:0] r_statStalls;

   // Saturating activity counters: grants count accepted requests, stalls
   // count cycles where a result is offered but not taken.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         r_statGrants <= '0;
         r_statStalls <= '0;
      end else begin
         if (w_handshake && (r_statGrants != 32'hFFFF_FFFF)) begin
            r_statGrants <= r_statGrants + 32'd1;
         end
         if (r_s2Valid && !bus.res_ready && (r_statStalls != 32'hFFFF_FFFF)) begin
            r_statStalls <= r_statStalls + 32'd1;
         end
      end
   end

   assign stat_grants = r_statGrants;
   assign stat_stalls = r_statStalls;
`endif

endmodule
